// File: rtl/bool_sweep_pkg.sv
// Shared state encoding and width helpers for the Boolean sweep checker.
package bool_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StCheck  = 2'd2,
    StDone   = 2'd3
  } sweep_state_e;

  // Bits needed to hold a count of 0..n.
  function automatic int unsigned pop_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to hold every (vector, channel) mismatch of a full sweep.
  function automatic int unsigned err_cnt_width(input int unsigned n_in, input int unsigned n_ch);
    return $clog2((32'd1 << n_in) * n_ch + 1);
  endfunction

endpackage

// File: rtl/bool_popcount.sv
// Combinational population count of a W-bit mismatch mask.
module bool_popcount
  import bool_sweep_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0]                   bits_i,
  output logic [pop_cnt_width(W)-1:0]    count_o
);

  localparam int unsigned CntW = pop_cnt_width(W);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CntW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/bool_sweep_checker.sv
// Sweeps every input vector of an N_IN-input function, compares N_CH implementation
// channels against a latched truth table and reports mismatch statistics.
module bool_sweep_checker
  import bool_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_CH   = 3,
  parameter int unsigned SETTLE = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  stop_on_fail,
  input  logic [(2**N_IN)-1:0]                  truth_table,
  output logic [N_IN-1:0]                       vec,
  input  logic [N_CH-1:0]                       ch_out,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  pass,
  output logic [err_cnt_width(N_IN, N_CH)-1:0]  err_count,
  output logic                                  fail_valid,
  output logic [N_IN-1:0]                       first_fail_idx,
  output logic [N_CH-1:0]                       first_fail_ch
);

  localparam int unsigned TtW  = 2 ** N_IN;
  localparam int unsigned ErrW = err_cnt_width(N_IN, N_CH);
  localparam int unsigned PopW = pop_cnt_width(N_CH);

  localparam logic [N_IN-1:0] VecLast    = {N_IN{1'b1}};
  localparam logic [3:0]      SettleLast = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  // With no settle time each vector goes straight to its check cycle.
  localparam sweep_state_e    StNextVec  = (SETTLE == 0) ? StCheck : StSettle;

  sweep_state_e     state_q;
  logic [TtW-1:0]   tt_q;
  logic             sof_q;
  logic [3:0]       cnt_q;
  logic [N_IN-1:0]  vec_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ErrW-1:0]  err_q;
  logic             fv_q;
  logic [N_IN-1:0]  ff_idx_q;
  logic [N_CH-1:0]  ff_ch_q;

  logic [N_CH-1:0]  miss;
  logic [PopW-1:0]  miss_cnt;
  logic [ErrW-1:0]  err_d;
  logic             miss_any;
  logic             sweep_end;

  assign miss      = ch_out ^ {N_CH{tt_q[vec_q]}};
  assign miss_any  = |miss;
  assign err_d     = err_q + ErrW'(miss_cnt);
  assign sweep_end = (vec_q == VecLast) || (sof_q && miss_any);

  bool_popcount #(
    .W (N_CH)
  ) u_popcount (
    .bits_i  (miss),
    .count_o (miss_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tt_q     <= '0;
      sof_q    <= 1'b0;
      cnt_q    <= '0;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      ff_idx_q <= '0;
      ff_ch_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            tt_q     <= truth_table;
            sof_q    <= stop_on_fail;
            cnt_q    <= '0;
            vec_q    <= '0;
            busy_q   <= 1'b1;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fv_q     <= 1'b0;
            ff_idx_q <= '0;
            ff_ch_q  <= '0;
            state_q  <= StNextVec;
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            state_q <= StCheck;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StCheck: begin
          err_q <= err_d;
          if (miss_any && !fv_q) begin
            fv_q     <= 1'b1;
            ff_idx_q <= vec_q;
            ff_ch_q  <= miss;
          end
          if (sweep_end) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
            state_q <= StDone;
          end else begin
            vec_q   <= vec_q + 1'b1;
            cnt_q   <= '0;
            state_q <= StNextVec;
          end
        end
        StDone: begin
          // A start arriving here is dropped; only IDLE accepts a new sweep.
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign vec            = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fv_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_ch  = ff_ch_q;

endmodule
